// File: rtl/execute_cycle.sv
// execute_cycle: execute stage of a five-stage RISC-V pipeline.
// Resolves operand forwarding, runs the ALU, and resolves beq branches.
// Results are registered into the EX/MEM pipeline register.
// The ID/EX register cannot be flushed, so a taken branch kills the two
// wrong-path instructions behind it using a small squash counter.
// Optional feature macro: EXECUTE_FORWARDING_EN. When it is defined, the
// M/W forwarding muxes are built. When it is undefined, register operands
// are used exactly as they arrive from ID/EX.
module execute_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        ResultSrcE,
  input  logic        BranchE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RD_E,
  input  logic [4:0]  Rs1_E,
  input  logic [4:0]  Rs2_E,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        SquashE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ResultSrcM,
  output logic [4:0]  RD_M,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Squash counter values: load on a taken branch, count down while killing.
  localparam logic [1:0] SQ_IDLE = 2'd0;
  localparam logic [1:0] SQ_LOAD = 2'd2;

  // 32-bit wrapping ALU. Undefined op codes return zero.
  function automatic logic [31:0] alu_f(input logic [2:0]  op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // EX/MEM pipeline register state
  logic        reg_write_q, reg_write_d;
  logic        mem_write_q, mem_write_d;
  logic        result_src_q, result_src_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] write_data_q, write_data_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic [1:0]  sq_q, sq_d;

  // Operand datapath
  logic [31:0] src_a_s;
  logic [31:0] rd2_fwd_s;
  logic [31:0] src_b_s;
  logic [31:0] alu_result_s;
  logic        zero_s;
  logic        squash_s;
  logic        pc_src_s;

`ifdef EXECUTE_FORWARDING_EN
  logic hit_m_a_s, hit_w_a_s, hit_m_b_s, hit_w_b_s;

  // A hit needs a live writer and a non-zero index, because x0 is never forwarded.
  assign hit_m_a_s = reg_write_q && (rd_q != 5'd0) && (rd_q == Rs1_E);
  assign hit_w_a_s = RegWriteW   && (RDW  != 5'd0) && (RDW  == Rs1_E);
  assign hit_m_b_s = reg_write_q && (rd_q != 5'd0) && (rd_q == Rs2_E);
  assign hit_w_b_s = RegWriteW   && (RDW  != 5'd0) && (RDW  == Rs2_E);

  // Forward source A. The younger M-stage result has priority over W.
  always_comb begin
    src_a_s = RD1_E;
    if (hit_m_a_s) begin
      src_a_s = alu_result_q;
    end else if (hit_w_a_s) begin
      src_a_s = ResultW;
    end else begin
      src_a_s = RD1_E;
    end
  end

  // Forward source B (store data and register operand). M has priority over W.
  always_comb begin
    rd2_fwd_s = RD2_E;
    if (hit_m_b_s) begin
      rd2_fwd_s = alu_result_q;
    end else if (hit_w_b_s) begin
      rd2_fwd_s = ResultW;
    end else begin
      rd2_fwd_s = RD2_E;
    end
  end
`else
  logic unused_fwd_s;

  // Without forwarding, hazards are the responsibility of software or NOP insertion.
  assign src_a_s      = RD1_E;
  assign rd2_fwd_s    = RD2_E;
  assign unused_fwd_s = ^{RegWriteW, RDW, ResultW, Rs1_E, Rs2_E};
`endif

  // The immediate selects only the ALU B input. Store data always uses RD2.
  assign src_b_s      = ALUSrcE ? Imm_Ext_E : rd2_fwd_s;
  assign alu_result_s = alu_f(ALUControlE, src_a_s, src_b_s);
  assign zero_s       = (alu_result_s == 32'd0);

  // A killed branch must neither redirect fetch nor restart the squash window.
  assign squash_s  = (sq_q != SQ_IDLE);
  assign pc_src_s  = BranchE & zero_s & ~squash_s;
  assign PCSrcE    = pc_src_s;
  assign PCTargetE = PCE + Imm_Ext_E;
  assign SquashE   = squash_s;

  // Squash counter next state: reload on a taken branch, otherwise drain to idle.
  always_comb begin
    sq_d = sq_q;
    if (pc_src_s) begin
      sq_d = SQ_LOAD;
    end else if (sq_q != SQ_IDLE) begin
      sq_d = sq_q - 2'd1;
    end else begin
      sq_d = SQ_IDLE;
    end
  end

  // EX/MEM next state. A killed instruction keeps its data but loses its side effects.
  always_comb begin
    reg_write_d  = RegWriteE & ~squash_s;
    mem_write_d  = MemWriteE & ~squash_s;
    result_src_d = ResultSrcE;
    rd_d         = RD_E;
    alu_result_d = alu_result_s;
    write_data_d = rd2_fwd_s;
    pc_plus4_d   = PCPlus4E;
  end

  // EX/MEM pipeline register and squash counter. The asynchronous reset drops any pending squash.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      rd_q         <= 5'd0;
      alu_result_q <= 32'd0;
      write_data_q <= 32'd0;
      pc_plus4_q   <= 32'd0;
      sq_q         <= SQ_IDLE;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
      sq_q         <= sq_d;
    end
  end

  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;
  assign RD_M       = rd_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign PCPlus4M   = pc_plus4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle: scoreboard bench for execute_cycle.
// The stimulus side pushes the expected EX/MEM contents from a behavioural model.
// A monitor pops and compares them after every rising edge.
module tb_execute_cycle;
  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RD_E, Rs1_E, Rs2_E;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;
  logic        PCSrcE, SquashE, RegWriteM, MemWriteM, ResultSrcM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RD_M;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .RD_E(RD_E), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .SquashE(SquashE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw, mw, rs;
    logic [4:0]  rd;
    logic [31:0] alu, wd, pc4;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // Model architectural state: the instruction now sitting in MEM and the kill window.
  logic        m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_alu;
  int          kill_left;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] mdl_operand(input logic [4:0] idx, input logic [31:0] val);
`ifdef EXECUTE_FORWARDING_EN
    if (idx != 5'd0 && m_rw && m_rd == idx) return m_alu;
    if (idx != 5'd0 && RegWriteW && RDW == idx) return ResultW;
`endif
    return val;
  endfunction

  function automatic logic [31:0] mdl_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: return (a[31] != b[31]) ? {31'd0, a[31]} : ((a < b) ? 32'd1 : 32'd0);
      default: return 32'd0;
    endcase
  endfunction

  // Run one cycle: check the same-cycle outputs, push the expected EX/MEM, then advance to the next negedge.
  task automatic step();
    logic [31:0] a, b, wd, res;
    logic        killed, taken;
    exp_t        e;
    #1;
    killed = (rst === 1'b1) && (kill_left > 0);
    a   = mdl_operand(Rs1_E, RD1_E);
    wd  = mdl_operand(Rs2_E, RD2_E);
    b   = ALUSrcE ? Imm_Ext_E : wd;
    res = mdl_alu(ALUControlE, a, b);
    taken = BranchE && (res == 32'd0) && !killed;
    chk("pcsrc", {31'd0, PCSrcE}, {31'd0, taken});
    chk("pctarget", PCTargetE, PCE + Imm_Ext_E);
    chk("squash", {31'd0, SquashE}, {31'd0, killed});
    if (rst !== 1'b1) begin
      e = '{rw: 1'b0, mw: 1'b0, rs: 1'b0, rd: 5'd0, alu: 32'd0, wd: 32'd0, pc4: 32'd0};
      kill_left = 0;
    end else begin
      e = '{rw: RegWriteE && !killed, mw: MemWriteE && !killed, rs: ResultSrcE,
            rd: RD_E, alu: res, wd: wd, pc4: PCPlus4E};
      if (taken) kill_left = 2;
      else if (kill_left > 0) kill_left = kill_left - 1;
    end
    m_rw  = e.rw;
    m_rd  = e.rd;
    m_alu = e.alu;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: compare the EX/MEM register against the oldest expected entry after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("RegWriteM", {31'd0, RegWriteM}, {31'd0, e.rw});
      chk("MemWriteM", {31'd0, MemWriteM}, {31'd0, e.mw});
      chk("ResultSrcM", {31'd0, ResultSrcM}, {31'd0, e.rs});
      chk("RD_M", {27'd0, RD_M}, {27'd0, e.rd});
      chk("ALUResultM", ALUResultM, e.alu);
      chk("WriteDataM", WriteDataM, e.wd);
      chk("PCPlus4M", PCPlus4M, e.pc4);
    end
  end

  task automatic neutral();
    RegWriteE = 1'b0; ALUSrcE = 1'b0; MemWriteE = 1'b0; ResultSrcE = 1'b0; BranchE = 1'b0;
    ALUControlE = 3'd0; RD1_E = 32'd0; RD2_E = 32'd0; Imm_Ext_E = 32'd0;
    PCE = 32'd0; PCPlus4E = 32'd4; RD_E = 5'd0; Rs1_E = 5'd0; Rs2_E = 5'd0;
    RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'd0;
  endtask

  task automatic rand_in();
    RegWriteE = 1'($urandom); ALUSrcE = 1'($urandom); MemWriteE = 1'($urandom);
    ResultSrcE = 1'($urandom); BranchE = ($urandom_range(0, 3) == 0);
    ALUControlE = 3'($urandom);
    RD1_E = $urandom; RD2_E = $urandom; Imm_Ext_E = $urandom;
    PCE = $urandom; PCPlus4E = $urandom;
    if ($urandom_range(0, 2) == 0) begin
      RD2_E = RD1_E; ALUControlE = 3'd1; ALUSrcE = 1'b0;
    end
    RD_E = 5'($urandom_range(0, 7)); Rs1_E = 5'($urandom_range(0, 7)); Rs2_E = 5'($urandom_range(0, 7));
    RegWriteW = 1'($urandom); RDW = 5'($urandom_range(0, 7)); ResultW = $urandom;
  endtask

  initial begin
    m_rw = 1'b0; m_rd = 5'd0; m_alu = 32'd0; kill_left = 0;
    rst = 1'b0;
    rand_in();
    @(negedge clk);
    chk("rst_RegWriteM", {31'd0, RegWriteM}, 32'd0);
    chk("rst_MemWriteM", {31'd0, MemWriteM}, 32'd0);
    chk("rst_ResultSrcM", {31'd0, ResultSrcM}, 32'd0);
    chk("rst_RD_M", {27'd0, RD_M}, 32'd0);
    chk("rst_ALUResultM", ALUResultM, 32'd0);
    chk("rst_WriteDataM", WriteDataM, 32'd0);
    chk("rst_PCPlus4M", PCPlus4M, 32'd0);
    chk("rst_SquashE", {31'd0, SquashE}, 32'd0);
    for (int i = 0; i < 3; i++) begin rand_in(); step(); end

    // First instruction after reset release.
    neutral(); rst = 1'b1;
    RegWriteE = 1'b1; RD1_E = 32'd5; RD2_E = 32'd7; RD_E = 5'd1;
    step();
    chk("add_result", ALUResultM, 32'd12);
    chk("add_regwrite", {31'd0, RegWriteM}, 32'd1);

    // ALU operation corner values.
    neutral(); ALUControlE = 3'd1; RD1_E = 32'd3; RD2_E = 32'd5; step();
    chk("sub_result", ALUResultM, 32'hFFFF_FFFE);
    neutral(); ALUControlE = 3'd5; RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1; step();
    chk("slt_result", ALUResultM, 32'd1);
    neutral(); ALUControlE = 3'd2; RD1_E = 32'h0000_F0F0; RD2_E = 32'h0000_FF00; step();
    chk("and_result", ALUResultM, 32'h0000_F000);
    neutral(); ALUSrcE = 1'b1; Imm_Ext_E = 32'h10; RD1_E = 32'd4; RD2_E = 32'h99; step();
    chk("imm_result", ALUResultM, 32'h14);
    chk("imm_storedata", WriteDataM, 32'h99);

    // Forwarding: x3 = 9 in MEM, x3 = 4 in WB, and a stale RD1.
    neutral(); RegWriteE = 1'b1; RD_E = 5'd3; RD1_E = 32'd9; step();
    neutral(); Rs1_E = 5'd3; RegWriteW = 1'b1; RDW = 5'd3; ResultW = 32'd4; step();
`ifdef EXECUTE_FORWARDING_EN
    chk("fwd_m_over_w", ALUResultM, 32'd9);
`else
    chk("nofwd_stale", ALUResultM, 32'd0);
`endif
    neutral(); Rs2_E = 5'd3; RD1_E = 32'd1; RegWriteW = 1'b1; RDW = 5'd3; ResultW = 32'd4; step();
`ifdef EXECUTE_FORWARDING_EN
    chk("fwd_w_b", ALUResultM, 32'd5);
    chk("fwd_w_store", WriteDataM, 32'd4);
`else
    chk("nofwd_b", ALUResultM, 32'd1);
`endif
    neutral(); RegWriteE = 1'b1; RD_E = 5'd0; RD1_E = 32'h55; step();
    neutral(); RD1_E = 32'h11; RegWriteW = 1'b1; RDW = 5'd0; ResultW = 32'h77; step();
    chk("x0_no_fwd", ALUResultM, 32'h11);

    // Taken branch, followed by a squashed branch and a normal instruction.
    neutral(); BranchE = 1'b1; ALUControlE = 3'd1; RD1_E = 32'h42; RD2_E = 32'h42;
    PCE = 32'h100; Imm_Ext_E = 32'h20;
    #1;
    chk("br_pcsrc", {31'd0, PCSrcE}, 32'd1);
    chk("br_target", PCTargetE, 32'h120);
    step();
    neutral(); RegWriteE = 1'b1; RD_E = 5'd5; BranchE = 1'b1; ALUControlE = 3'd1;
    RD1_E = 32'h7; RD2_E = 32'h7;
    #1;
    chk("sq1_squash", {31'd0, SquashE}, 32'd1);
    chk("sq1_pcsrc", {31'd0, PCSrcE}, 32'd0);
    step();
    chk("sq1_regwrite", {31'd0, RegWriteM}, 32'd0);
    neutral(); RegWriteE = 1'b1; RD_E = 5'd6;
    #1; chk("sq2_squash", {31'd0, SquashE}, 32'd1);
    step();
    chk("sq2_regwrite", {31'd0, RegWriteM}, 32'd0);
    neutral(); RegWriteE = 1'b1; RD_E = 5'd7;
    #1; chk("sq3_squash", {31'd0, SquashE}, 32'd0);
    step();
    chk("sq3_regwrite", {31'd0, RegWriteM}, 32'd1);

    // Reset during the squash window.
    neutral(); BranchE = 1'b1; ALUControlE = 3'd1; step();
    rst = 1'b0; neutral();
    #1; chk("rstsq_squash", {31'd0, SquashE}, 32'd0);
    step();
    rst = 1'b1; neutral(); RegWriteE = 1'b1; RD_E = 5'd2; RD1_E = 32'd1; RD2_E = 32'd1;
    #1; chk("rstsq_after", {31'd0, SquashE}, 32'd0);
    step();
    chk("rstsq_commit", {31'd0, RegWriteM}, 32'd1);
    chk("rstsq_result", ALUResultM, 32'd2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      step();
    end
    rst = 1'b1; neutral(); step();

    if (sbq.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain actual=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
